// File: rtl/simd_mac_pkg.sv
// Shared types and helpers for the SIMD multiply-accumulate engine:
// derived datapath widths, the beat tag carried beside the data, and the
// round / saturate arithmetic applied to the accumulator on output.
package simd_mac_pkg;

  // Working width for output scaling; comfortably wider than any accumulator.
  localparam int WIDE_W = 128;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_tag_t;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic int sum_w(input int a_w, input int b_w, input int lanes);
    return prod_w(a_w, b_w) + $clog2(lanes);
  endfunction

  function automatic int acc_w(input int a_w, input int b_w, input int lanes, input int beats);
    return sum_w(a_w, b_w, lanes) + $clog2(beats);
  endfunction

  // Arithmetic right shift with round-half-up; shift <= 0 passes through.
  function automatic logic signed [WIDE_W-1:0] round_shift(input logic signed [WIDE_W-1:0] v,
                                                           input int shift);
    logic signed [WIDE_W-1:0] half;
    if (shift <= 0) return v;
    half = {{(WIDE_W-1){1'b0}}, 1'b1} << (shift - 1);
    return (v + half) >>> shift;
  endfunction

  // Clamp to the signed range of out_w bits; flags when clamping happened.
  function automatic logic signed [WIDE_W-1:0] sat_clamp(input logic signed [WIDE_W-1:0] v,
                                                         input int out_w,
                                                         output logic clamped);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = ({{(WIDE_W-1){1'b0}}, 1'b1} << (out_w - 1)) - WIDE_W'(1);
    lo = ~hi;
    clamped = 1'b0;
    if (v > hi) begin
      clamped = 1'b1;
      return hi;
    end
    if (v < lo) begin
      clamped = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/simd_dot_pipe.sv
// Two-stage dot-product pipe: lane multipliers registered in P, adder
// tree registered in S. Beat tags travel alongside; everything holds
// while en_i is low so a stalled beat is never lost or duplicated.
module simd_dot_pipe
  import simd_mac_pkg::*;
#(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int SIMD_WIDTH = 36,
  localparam int PROD_W    = prod_w(A_WIDTH, B_WIDTH),
  localparam int SUM_W     = sum_w(A_WIDTH, B_WIDTH, SIMD_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  beat_tag_t                 tag_i,
  input  logic signed [A_WIDTH-1:0] a_i [SIMD_WIDTH],
  input  logic signed [B_WIDTH-1:0] b_i [SIMD_WIDTH],
  output logic signed [SUM_W-1:0]   sum_o,
  output beat_tag_t                 tag_o
);

  logic signed [PROD_W-1:0] prod_d [SIMD_WIDTH];
  logic signed [PROD_W-1:0] prod_q [SIMD_WIDTH];
  logic signed [SUM_W-1:0]  sum_d;
  logic signed [SUM_W-1:0]  sum_q;
  beat_tag_t                tag_p_q;
  beat_tag_t                tag_s_q;

  // Lane multipliers, operands sign-extended to the full product width.
  always_comb begin
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      prod_d[i] = PROD_W'(a_i[i]) * PROD_W'(b_i[i]);
    end
  end

  // P stage boundary: product registers, no reset on data.
  always_ff @(posedge clk_i) begin
    if (en_i) prod_q <= prod_d;
  end

  // Sign-extended reduction of the registered products.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
  end

  // S stage boundary: tree sum register, no reset on data.
  always_ff @(posedge clk_i) begin
    if (en_i) sum_q <= sum_d;
  end

  // Tags for the P and S stages; only these are cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_p_q <= '0;
      tag_s_q <= '0;
    end else if (en_i) begin
      tag_p_q <= tag_i;
      tag_s_q <= tag_p_q;
    end
  end

  assign sum_o = sum_q;
  assign tag_o = tag_s_q;

endmodule

// File: rtl/simd_mac_acc.sv
// SIMD multiply-accumulate engine top: dot-product pipe followed by the
// accumulator / output stage (A), beat counter and valid/ready handling.
// A single enable stalls all three stages together while a result waits.
// Optional build macro MAC_SATURATE_EN: clamp the scaled result instead of
// wrapping it, and expose out_sat alongside out_valid.
module simd_mac_acc
  import simd_mac_pkg::*;
#(
  parameter int A_WIDTH       = 16,
  parameter int B_WIDTH       = 16,
  parameter int SIMD_WIDTH    = 36,
  parameter int ACC_BEATS_MAX = 64,
  parameter int OUTPUT_WIDTH  = 16,
  parameter int OUTPUT_SCALE  = 0
) (
  input  logic                           clk,
  input  logic                           rst_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic signed [A_WIDTH-1:0]      a [0:SIMD_WIDTH-1],
  input  logic signed [B_WIDTH-1:0]      b [0:SIMD_WIDTH-1],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] out,
`ifdef MAC_SATURATE_EN
  output logic                           out_sat,
`endif
  output logic                           beat_err
);

  localparam int SUM_W = sum_w(A_WIDTH, B_WIDTH, SIMD_WIDTH);
  localparam int ACC_W = acc_w(A_WIDTH, B_WIDTH, SIMD_WIDTH, ACC_BEATS_MAX);
  localparam int CNT_W = $clog2(ACC_BEATS_MAX + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_BEATS_MAX);

  logic                           en;
  beat_tag_t                      tag_in;
  beat_tag_t                      tag_s;
  logic signed [SUM_W-1:0]        sum_s;

  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic                           open_q, open_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           out_valid_q, out_valid_d;
  logic signed [OUTPUT_WIDTH-1:0] out_q, out_d;
  logic                           beat_err_q, beat_err_d;
`ifdef MAC_SATURATE_EN
  logic                           out_sat_q, out_sat_d;
`endif

  logic                           start;
  logic signed [ACC_W-1:0]        acc_next;
  logic [CNT_W-1:0]               cnt_next;
  logic signed [WIDE_W-1:0]       scaled;
`ifdef MAC_SATURATE_EN
  logic signed [WIDE_W-1:0]       clamped;
  logic                           sat_flag;
`endif

  assign en     = !out_valid_q || out_ready;
  assign tag_in = {in_valid, in_first, in_last};

  simd_dot_pipe #(
    .A_WIDTH   (A_WIDTH),
    .B_WIDTH   (B_WIDTH),
    .SIMD_WIDTH(SIMD_WIDTH)
  ) u_dot (
    .clk_i (clk),
    .rst_i (rst_in),
    .en_i  (en),
    .tag_i (tag_in),
    .a_i   (a),
    .b_i   (b),
    .sum_o (sum_s),
    .tag_o (tag_s)
  );

  // A stage next state: accumulate, close on last, track beats and output handshake.
  always_comb begin
    acc_d       = acc_q;
    open_d      = open_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    beat_err_d  = beat_err_q;
    start       = tag_s.first || !open_q;
    acc_next    = start ? ACC_W'(sum_s) : acc_q + ACC_W'(sum_s);
    cnt_next    = start ? CNT_W'(1) : ((cnt_q > CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
    scaled      = round_shift(WIDE_W'(acc_next), OUTPUT_SCALE);
`ifdef MAC_SATURATE_EN
    out_sat_d   = out_sat_q;
    sat_flag    = 1'b0;
    clamped     = sat_clamp(scaled, OUTPUT_WIDTH, sat_flag);
`endif
    if (en) begin
      out_valid_d = 1'b0;
      if (tag_s.valid) begin
        acc_d = acc_next;
        if (tag_s.last) begin
          open_d      = 1'b0;
          cnt_d       = '0;
          out_valid_d = 1'b1;
`ifdef MAC_SATURATE_EN
          out_d       = OUTPUT_WIDTH'(clamped);
          out_sat_d   = sat_flag;
`else
          out_d       = OUTPUT_WIDTH'(scaled);
`endif
        end else begin
          open_d = 1'b1;
          cnt_d  = cnt_next;
          if (cnt_next > CNT_MAX) beat_err_d = 1'b1;
        end
      end
    end
  end

  // A stage boundary: accumulator, counter, output register and sticky error.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      acc_q       <= '0;
      open_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      beat_err_q  <= 1'b0;
`ifdef MAC_SATURATE_EN
      out_sat_q   <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      open_q      <= open_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      beat_err_q  <= beat_err_d;
`ifdef MAC_SATURATE_EN
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign beat_err  = beat_err_q;
`ifdef MAC_SATURATE_EN
  assign out_sat   = out_sat_q;
`endif

endmodule

// File: tb/tb_simd_mac_acc.sv
// Scoreboard bench for simd_mac_acc. Two instances share one stimulus
// stream: dut0 with default scaling/width, dut1 with OUTPUT_SCALE=4 and
// OUTPUT_WIDTH=8 to exercise rounding and overflow handling.
`timescale 1ns/1ps
module tb_simd_mac_acc;

  localparam int LANES = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_in, in_valid, in_first, in_last, out_ready;
  logic signed [15:0] a_drv [0:LANES-1];
  logic signed [15:0] b_drv [0:LANES-1];
  logic ir0, ir1, ov0, ov1, be0, be1, os0, os1;
  logic signed [15:0] out0;
  logic signed [7:0]  out1;

  int n_tests = 0;
  int n_fail  = 0;
  longint expq0[$];
  longint expq1[$];
  bit     satq0[$];
  bit     satq1[$];
  bit     open_m = 1'b0;
  longint acc_m  = 0;
  int     cnt_m  = 0;
  bit     bp_rand = 1'b0;
  int     st;

  simd_mac_acc #(.A_WIDTH(16), .B_WIDTH(16), .SIMD_WIDTH(LANES), .ACC_BEATS_MAX(64),
                 .OUTPUT_WIDTH(16), .OUTPUT_SCALE(0)) dut0 (
    .clk(clk), .rst_in(rst_in), .in_valid(in_valid), .in_ready(ir0),
    .in_first(in_first), .in_last(in_last), .a(a_drv), .b(b_drv),
    .out_valid(ov0), .out_ready(out_ready), .out(out0),
`ifdef MAC_SATURATE_EN
    .out_sat(os0),
`endif
    .beat_err(be0));

  simd_mac_acc #(.A_WIDTH(16), .B_WIDTH(16), .SIMD_WIDTH(LANES), .ACC_BEATS_MAX(64),
                 .OUTPUT_WIDTH(8), .OUTPUT_SCALE(4)) dut1 (
    .clk(clk), .rst_in(rst_in), .in_valid(in_valid), .in_ready(ir1),
    .in_first(in_first), .in_last(in_last), .a(a_drv), .b(b_drv),
    .out_valid(ov1), .out_ready(out_ready), .out(out1),
`ifdef MAC_SATURATE_EN
    .out_sat(os1),
`endif
    .beat_err(be1));

`ifndef MAC_SATURATE_EN
  assign os0 = 1'b0;
  assign os1 = 1'b0;
`endif

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: real-valued round-half-up division, then wrap or clamp.
  function automatic longint model_out(input longint acc, input int sc, input int ow,
                                       output bit sat);
    longint r, hi, lo, m;
    r   = (sc > 0) ? ((acc + (longint'(1) <<< (sc - 1))) >>> sc) : acc;
    hi  = (longint'(1) <<< (ow - 1)) - 1;
    lo  = -hi - 1;
    m   = longint'(1) <<< ow;
    sat = 1'b0;
`ifdef MAC_SATURATE_EN
    if (r > hi) begin sat = 1'b1; return hi; end
    if (r < lo) begin sat = 1'b1; return lo; end
    return r;
`else
    r = r % m;
    if (r < 0) r += m;
    if (r > hi) r -= m;
    return r;
`endif
  endfunction

  task automatic rand_lanes();
    for (int i = 0; i < LANES; i++) begin
      a_drv[i] = 16'($urandom);
      b_drv[i] = 16'($urandom);
    end
  endtask

  task automatic fill_lanes(input int av, input int bv);
    for (int i = 0; i < LANES; i++) begin
      a_drv[i] = 16'(av);
      b_drv[i] = 16'(bv);
    end
  endtask

  task automatic lane0(input int av);
    fill_lanes(0, 0);
    a_drv[0] = 16'(av);
    b_drv[0] = 16'sd1;
  endtask

  // Present one beat until accepted, then update the reference model.
  task automatic send_beat(input bit first, input bit last, output int stalls);
    longint s;
    bit sat;
    longint e;
    in_valid = 1'b1; in_first = first; in_last = last;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (ir0) break;
      stalls++;
      if (stalls > 200) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: in_ready stayed low for %0d cycles, required 1 within 200", stalls);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    s = 0;
    for (int i = 0; i < LANES; i++) s += longint'(a_drv[i]) * longint'(b_drv[i]);
    if (first || !open_m) begin acc_m = s; cnt_m = 1; end
    else begin acc_m += s; cnt_m++; end
    if (last) begin
      e = model_out(acc_m, 0, 16, sat); expq0.push_back(e); satq0.push_back(sat);
      e = model_out(acc_m, 4, 8, sat);  expq1.push_back(e); satq1.push_back(sat);
      open_m = 1'b0; cnt_m = 0;
    end else begin
      open_m = 1'b1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq0.size() != 0 || expq1.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (expq0.size() != 0 || expq1.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d/%0d results still pending, required 0", expq0.size(), expq1.size());
      expq0.delete(); expq1.delete(); satq0.delete(); satq1.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic mon_step(input int d, input logic v, input logic irdy, input longint val,
                          input logic sat, inout bit hold, inout longint held);
    longint e;
    bit es;
    chk($sformatf("in_ready%0d", d), longint'(irdy), longint'(!(v && !out_ready)));
    if (hold) begin
      chk($sformatf("hold_valid%0d", d), longint'(v), 1);
      chk($sformatf("hold_out%0d", d), val, held);
    end
    hold = v && !out_ready;
    held = val;
    if (v && out_ready) begin
      if ((d == 0 && expq0.size() == 0) || (d == 1 && expq1.size() == 0)) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out%0d: got %0d, required no output", d, val);
      end else begin
        if (d == 0) begin e = expq0.pop_front(); es = satq0.pop_front(); end
        else begin e = expq1.pop_front(); es = satq1.pop_front(); end
        chk($sformatf("out%0d", d), val, e);
`ifdef MAC_SATURATE_EN
        chk($sformatf("out_sat%0d", d), longint'(sat), longint'(es));
`else
        if (sat != es) $display("note: sat tag differs on dut%0d", d);
`endif
      end
    end
  endtask

  // Monitor: compares every delivered result against the scoreboard.
  initial begin
    bit hold0, hold1;
    longint held0, held1;
    hold0 = 1'b0; hold1 = 1'b0; held0 = 0; held1 = 0;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        hold0 = 1'b0; hold1 = 1'b0;
      end else begin
        mon_step(0, ov0, ir0, longint'(out0), os0, hold0, held0);
        mon_step(1, ov1, ir1, longint'(out1), os1, hold1, held1);
      end
    end
  end

  // Random backpressure driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst_in = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    fill_lanes(0, 0);
    repeat (3) @(posedge clk);
    #1 rst_in = 1'b0;
    chk("rst_out_valid0", ov0, 0); chk("rst_out_valid1", ov1, 0);
    chk("rst_in_ready0", ir0, 1);  chk("rst_in_ready1", ir1, 1);
    chk("rst_beat_err0", be0, 0);  chk("rst_beat_err1", be1, 0);
    chk("rst_out0", out0, 0);      chk("rst_out1", out1, 0);

    // Single-beat result and latency.
    fill_lanes(2, 3);
    send_beat(1'b1, 1'b1, st);
    @(posedge clk); #1; chk("lat_edge_k1", ov0, 0);
    @(posedge clk); #1; chk("lat_edge_k2", ov0, 1);
    wait_drain();

    // Four back-to-back beats, one result.
    fill_lanes(1, 1);
    send_beat(1'b1, 1'b0, st); chk("b2b_stall0", st, 0);
    send_beat(1'b0, 1'b0, st); chk("b2b_stall1", st, 0);
    send_beat(1'b0, 1'b0, st); chk("b2b_stall2", st, 0);
    send_beat(1'b0, 1'b1, st); chk("b2b_stall3", st, 0);
    wait_drain();

    // Rounding and overflow corner values.
    lane0(24);    send_beat(1'b1, 1'b1, st);
    lane0(-24);   send_beat(1'b1, 1'b1, st);
    lane0(23);    send_beat(1'b1, 1'b1, st);
    lane0(4800);  send_beat(1'b1, 1'b1, st);
    lane0(-4800); send_beat(1'b1, 1'b1, st);
    wait_drain();

    // Backpressure: results pile up while out_ready is low.
    out_ready = 1'b0;
    fork
      begin
        for (int j = 0; j < 4; j++) begin
          rand_lanes();
          send_beat(1'b1, 1'b1, st);
          if (j == 3) chk("bp_stalled", longint'(st >= 5), 1);
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Random framing with random backpressure.
    bp_rand = 1'b1;
    for (int g = 0; g < 60; g++) begin
      int len;
      bit fst, cls;
      len = $urandom_range(1, 6);
      fst = ($urandom_range(0, 3) != 0) || (cnt_m > 50);
      cls = ($urandom_range(0, 5) != 0);
      for (int j = 0; j < len; j++) begin
        rand_lanes();
        if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        send_beat((j == 0) && fst, (j == len - 1) && cls, st);
      end
    end
    bp_rand = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of an accumulation.
    rand_lanes();
    send_beat(1'b1, 1'b0, st);
    send_beat(1'b0, 1'b0, st);
    rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0;
    open_m = 1'b0; cnt_m = 0;
    lane0(5);
    send_beat(1'b1, 1'b1, st);
    wait_drain();
    chk("rst_mid_beat_err0", be0, 0); chk("rst_mid_beat_err1", be1, 0);

    // Beat overrun: 64 beats legal, the 65th without last flags the error.
    rand_lanes();
    send_beat(1'b1, 1'b0, st);
    for (int j = 1; j < 64; j++) send_beat(1'b0, 1'b0, st);
    repeat (3) @(posedge clk); #1;
    chk("beats64_err0", be0, 0); chk("beats64_err1", be1, 0);
    send_beat(1'b0, 1'b0, st);
    repeat (3) @(posedge clk); #1;
    chk("beats65_err0", be0, 1); chk("beats65_err1", be1, 1);
    send_beat(1'b1, 1'b0, st);
    repeat (5) @(posedge clk); #1;
    chk("err_sticky0", be0, 1); chk("err_sticky1", be1, 1);
    rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0;
    open_m = 1'b0; cnt_m = 0;
    chk("err_cleared0", be0, 0); chk("err_cleared1", be1, 0);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
